// File: rtl/lvt_wr_sched_if.sv
// Request/read handshake bundle between the requesters and the LVT write scheduler.
// Valid/ready rule: a transfer happens in a cycle where valid and ready are both
// high at the rising clock edge; a requester holds valid and its payload stable
// until it sees ready.
interface lvt_wr_sched_if #(
  parameter int NREQ = 4,
  parameter int AW   = 7,
  parameter int DW   = 5
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rd_valid_in;
  logic [AW-1:0]      rd_addr;
  logic               rd_ready;
  logic               rd_valid;
  logic [DW-1:0]      rd_data;

  // Requester side
  modport master (
    output req_valid, req_addr, req_data, rd_valid_in, rd_addr,
    input  req_ready, rd_ready, rd_valid, rd_data
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_addr, req_data, rd_valid_in, rd_addr,
    output req_ready, rd_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/lvt_wr_sched.sv
// LVT write scheduler: after a zero-fill sweep of the memory, arbitrates four
// write requesters onto two LVT write ports (round-robin, second grant must hit a
// different address than the first) and pipelines single-port reads.
module lvt_wr_sched #(
  parameter int NREQ = 4,
  parameter int AW   = 7,
  parameter int DW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_clear,
  lvt_wr_sched_if.slave bus,
  output logic          wr0_en,
  output logic [AW-1:0] wr0_addr,
  output logic [DW-1:0] wr0_data,
  output logic          wr1_en,
  output logic [AW-1:0] wr1_addr,
  output logic [DW-1:0] wr1_data,
  output logic          rd0_en,
  output logic [AW-1:0] rd0_addr,
  input  logic [DW-1:0] rd0_data,
  output logic          init_done,
  output logic [7:0]    coll_cnt,
  output logic          dbg_state
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t          state;
  logic [AW-1:0]   sweep;
  logic [1:0]      ptr;
  logic            rd_valid_q;

  logic            a_vld;
  logic            b_vld;
  logic            coll;
  logic [1:0]      a_idx;
  logic [1:0]      b_idx;
  logic [1:0]      idx;
  logic [AW-1:0]   a_addr;
  logic [AW-1:0]   b_addr;
  logic [AW-1:0]   cur_addr;
  logic [DW-1:0]   a_data;
  logic [DW-1:0]   b_data;
  logic [NREQ-1:0] grant;
  logic            rd_hs;

  // Round-robin scan from ptr: first valid wins port 0, next valid with a
  // different address wins port 1; same-address requesters met before port 1 is
  // filled are collisions. No grants on the cycle cfg_clear is taken, since the
  // following cycle already belongs to the sweep.
  always_comb begin
    a_vld    = 1'b0;
    b_vld    = 1'b0;
    coll     = 1'b0;
    a_idx    = 2'd0;
    b_idx    = 2'd0;
    idx      = ptr;
    a_addr   = '0;
    b_addr   = '0;
    cur_addr = '0;
    a_data   = '0;
    b_data   = '0;
    if (state == RUN && !cfg_clear) begin
      for (int k = 0; k < 4; k++) begin
        idx      = ptr + 2'(k);
        cur_addr = bus.req_addr[int'(idx)*AW +: AW];
        if (bus.req_valid[idx] && !b_vld) begin
          if (!a_vld) begin
            a_vld  = 1'b1;
            a_idx  = idx;
            a_addr = cur_addr;
            a_data = bus.req_data[int'(idx)*DW +: DW];
          end else if (cur_addr == a_addr) begin
            coll = 1'b1;
          end else begin
            b_vld  = 1'b1;
            b_idx  = idx;
            b_addr = cur_addr;
            b_data = bus.req_data[int'(idx)*DW +: DW];
          end
        end
      end
    end
  end

  // One-hot ready per granted requester.
  always_comb begin
    grant = '0;
    if (a_vld) grant[a_idx] = 1'b1;
    if (b_vld) grant[b_idx] = 1'b1;
  end

  assign rd_hs         = bus.rd_valid_in && (state == RUN);
  assign bus.req_ready = grant;
  assign bus.rd_ready  = (state == RUN);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd0_data;
  assign init_done     = (state == RUN);
  assign dbg_state     = state;

  // Control FSM with registered memory-port outputs; the read pipeline keeps
  // running across cfg_clear so in-flight reads still complete.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= INIT;
      sweep      <= '0;
      ptr        <= 2'd0;
      coll_cnt   <= 8'd0;
      wr0_en     <= 1'b0;
      wr0_addr   <= '0;
      wr0_data   <= '0;
      wr1_en     <= 1'b0;
      wr1_addr   <= '0;
      wr1_data   <= '0;
      rd0_en     <= 1'b0;
      rd0_addr   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd0_en     <= rd_hs;
      rd0_addr   <= bus.rd_addr;
      rd_valid_q <= rd0_en;
      case (state)
        INIT: begin
          wr0_en   <= 1'b1;
          wr0_addr <= sweep;
          wr0_data <= '0;
          wr1_en   <= 1'b0;
          sweep    <= sweep + 1'b1;
          if (sweep == {AW{1'b1}}) state <= RUN;
        end
        RUN: begin
          if (cfg_clear) begin
            state  <= INIT;
            sweep  <= '0;
            wr0_en <= 1'b0;
            wr1_en <= 1'b0;
          end else begin
            wr0_en   <= a_vld;
            wr0_addr <= a_addr;
            wr0_data <= a_data;
            wr1_en   <= b_vld;
            wr1_addr <= b_addr;
            wr1_data <= b_data;
            if (b_vld)      ptr <= b_idx + 2'd1;
            else if (a_vld) ptr <= a_idx + 2'd1;
            if (coll && coll_cnt != 8'hFF) coll_cnt <= coll_cnt + 8'd1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lvt_wr_sched.sv
// Bench for lvt_wr_sched: attached behavioural LVT memory, reference model of
// arbitration/sweep/read latency, directed scenarios plus randomized traffic.
module tb_lvt_wr_sched;
  localparam int AW = 7;
  localparam int DW = 5;

  logic          clk;
  logic          rst;
  logic          cfg_clear;
  logic          wr0_en, wr1_en, rd0_en;
  logic [AW-1:0] wr0_addr, wr1_addr, rd0_addr;
  logic [DW-1:0] wr0_data, wr1_data;
  logic [DW-1:0] rd0_data;
  logic          init_done;
  logic [7:0]    coll_cnt;
  logic          dbg_state;

  lvt_wr_sched_if #(.NREQ(4), .AW(AW), .DW(DW)) bus ();

  lvt_wr_sched #(.NREQ(4), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_clear (cfg_clear),
    .bus       (bus.slave),
    .wr0_en    (wr0_en),
    .wr0_addr  (wr0_addr),
    .wr0_data  (wr0_data),
    .wr1_en    (wr1_en),
    .wr1_addr  (wr1_addr),
    .wr1_data  (wr1_data),
    .rd0_en    (rd0_en),
    .rd0_addr  (rd0_addr),
    .rd0_data  (rd0_data),
    .init_done (init_done),
    .coll_cnt  (coll_cnt),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural LVT memory: read-first, data one cycle after rd0_en.
  logic [DW-1:0] ram [128];
  always @(posedge clk) begin
    if (rd0_en === 1'b1) rd0_data <= ram[rd0_addr];
    if (wr0_en === 1'b1) ram[wr0_addr] <= wr0_data;
    if (wr1_en === 1'b1) ram[wr1_addr] <= wr1_data;
  end

  // driver state
  logic          drv_rst, drv_clr, drv_rd;
  logic [AW-1:0] drv_rd_addr;
  logic          drv_valid [4];
  logic [AW-1:0] drv_addr [4];
  logic [DW-1:0] drv_data [4];

  // reference model
  bit            m_known, m_init;
  int            m_sweep, m_ptr, m_coll;
  logic [DW-1:0] ref_mem [128];
  logic          e_wr0_en, e_wr1_en, e_rd0_en, e_rdv;
  logic [AW-1:0] e_wr0_addr, e_wr1_addr, e_rd0_addr;
  logic [DW-1:0] e_wr0_data, e_wr1_data;
  logic [DW-1:0] exp_q [$];

  // observations of the latest cycle
  logic [3:0]    exp_hs, obs_ready;
  logic          obs_rdv;
  logic [DW-1:0] obs_rdd;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Arbitration rule: scan ptr, ptr+1, ... ; first valid is A; afterwards the
  // first valid with an address different from A is B; same-address ones met
  // before B count as a collision.
  task automatic model_grant(output logic [3:0] g, output int a, output int b, output bit coll);
    int order [$];
    g = '0; a = -1; b = -1; coll = 0;
    for (int k = 0; k < 4; k++)
      if (drv_valid[(m_ptr + k) % 4]) order.push_back((m_ptr + k) % 4);
    if (order.size() > 0) begin
      a = order[0];
      g[a] = 1'b1;
      for (int j = 1; j < order.size(); j++) begin
        if (drv_addr[order[j]] == drv_addr[a]) coll = 1;
        else begin
          b = order[j];
          g[b] = 1'b1;
          break;
        end
      end
    end
  endtask

  // one clock cycle: drive, check, advance model
  task automatic step();
    logic [3:0] g;
    int a, b;
    bit coll;
    bit rd_hs;
    @(posedge clk);
    #1;
    rst       = drv_rst;
    cfg_clear = drv_clr;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i]          = drv_valid[i];
      bus.req_addr[i*AW +: AW]  = drv_addr[i];
      bus.req_data[i*DW +: DW]  = drv_data[i];
    end
    bus.rd_valid_in = drv_rd;
    bus.rd_addr     = drv_rd_addr;
    #1;
    obs_ready = bus.req_ready;
    obs_rdv   = bus.rd_valid;
    obs_rdd   = bus.rd_data;
    g = '0; a = -1; b = -1; coll = 0;
    if (m_known && !m_init && !drv_clr) model_grant(g, a, b, coll);
    if (m_known) begin
      chk("req_ready", bus.req_ready, g);
      chk("rd_ready", bus.rd_ready, !m_init);
      chk("init_done", init_done, !m_init);
      chk("dbg_state", dbg_state, !m_init);
      chk("coll_cnt", coll_cnt, m_coll);
      chk("wr0_en", wr0_en, e_wr0_en);
      if (e_wr0_en) begin
        chk("wr0_addr", wr0_addr, e_wr0_addr);
        chk("wr0_data", wr0_data, e_wr0_data);
      end
      chk("wr1_en", wr1_en, e_wr1_en);
      if (e_wr1_en) begin
        chk("wr1_addr", wr1_addr, e_wr1_addr);
        chk("wr1_data", wr1_data, e_wr1_data);
      end
      chk("rd0_en", rd0_en, e_rd0_en);
      if (e_rd0_en) chk("rd0_addr", rd0_addr, e_rd0_addr);
      chk("rd_valid", bus.rd_valid, e_rdv);
      if (e_rdv) begin
        chk("rd_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("rd_data", bus.rd_data, exp_q.pop_front());
      end
    end
    exp_hs = g;
    if (!drv_rst) begin
      m_known = 1; m_init = 1; m_sweep = 0; m_ptr = 0; m_coll = 0;
      e_wr0_en = 0; e_wr1_en = 0; e_rd0_en = 0; e_rdv = 0;
      exp_q.delete();
    end else if (m_known) begin
      e_rdv      = e_rd0_en;
      rd_hs      = !m_init && drv_rd;
      e_rd0_en   = rd_hs;
      e_rd0_addr = drv_rd_addr;
      if (rd_hs) exp_q.push_back(ref_mem[drv_rd_addr]);
      if (m_init) begin
        e_wr0_en = 1; e_wr0_addr = AW'(m_sweep); e_wr0_data = '0; e_wr1_en = 0;
        ref_mem[m_sweep] = '0;
        if (m_sweep == 127) m_init = 0;
        m_sweep++;
      end else if (drv_clr) begin
        m_init = 1; m_sweep = 0; e_wr0_en = 0; e_wr1_en = 0;
      end else begin
        e_wr0_en = (a >= 0);
        e_wr1_en = (b >= 0);
        if (a >= 0) begin
          e_wr0_addr = drv_addr[a]; e_wr0_data = drv_data[a];
          ref_mem[drv_addr[a]] = drv_data[a];
        end
        if (b >= 0) begin
          e_wr1_addr = drv_addr[b]; e_wr1_data = drv_data[b];
          ref_mem[drv_addr[b]] = drv_data[b];
        end
        if (b >= 0)      m_ptr = (b + 1) % 4;
        else if (a >= 0) m_ptr = (a + 1) % 4;
        if (coll && m_coll < 255) m_coll++;
      end
    end
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 4; i++) begin
      drv_valid[i] = 1'b0; drv_addr[i] = '0; drv_data[i] = '0;
    end
    drv_rd = 1'b0; drv_rd_addr = '0; drv_clr = 1'b0;
  endtask

  // step until the sweep finishes; counts sweep write cycles
  task automatic wait_init(input string tag);
    int sw;
    sw = 0;
    for (int n = 0; n < 300; n++) begin
      step();
      if (wr0_en === 1'b1) sw++;
      if (init_done === 1'b1) break;
    end
    chk({tag, "_init_done"}, init_done, 1);
    chk({tag, "_sweep_len"}, sw, 128);
  endtask

  task automatic rand_traffic(input int cycles, input int addr_max);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!drv_valid[i] && $urandom_range(0, 99) < 60) begin
          drv_valid[i] = 1'b1;
          drv_addr[i]  = AW'($urandom_range(0, addr_max));
          drv_data[i]  = DW'($urandom_range(0, 31));
        end
      end
      drv_rd      = 1'($urandom_range(0, 1));
      drv_rd_addr = AW'($urandom_range(0, addr_max));
      step();
      for (int i = 0; i < 4; i++) if (exp_hs[i]) drv_valid[i] = 1'b0;
    end
  endtask

  initial begin
    m_known = 0; m_init = 1; m_sweep = 0; m_ptr = 0; m_coll = 0;
    e_wr0_en = 0; e_wr1_en = 0; e_rd0_en = 0; e_rdv = 0;
    idle_inputs();
    drv_rst = 1'b0;
    repeat (3) step();
    drv_rst = 1'b1;
    chk("rst_init_done", init_done, 0);
    chk("rst_coll_cnt", coll_cnt, 0);
    wait_init("boot");

    // four distinct requesters held valid: pairs 0/1 and 2/3 alternate
    for (int i = 0; i < 4; i++) begin
      drv_valid[i] = 1'b1; drv_addr[i] = AW'(8'h40 + i); drv_data[i] = DW'(i + 3);
    end
    step(); chk("rr_g01_a", obs_ready, 4'b0011);
    step(); chk("rr_g23", obs_ready, 4'b1100);
    step(); chk("rr_g01_b", obs_ready, 4'b0011);
    step(); chk("rr_g23_b", obs_ready, 4'b1100);

    // collision: req0/req1 share 0x10, req2 at 0x20
    idle_inputs();
    drv_valid[0] = 1'b1; drv_addr[0] = 7'h10; drv_data[0] = 5'h01;
    drv_valid[1] = 1'b1; drv_addr[1] = 7'h10; drv_data[1] = 5'h02;
    drv_valid[2] = 1'b1; drv_addr[2] = 7'h20; drv_data[2] = 5'h03;
    step(); chk("coll_grant", obs_ready, 4'b0101);
    chk("coll_before", coll_cnt, 0);
    idle_inputs();
    step(); chk("coll_after", coll_cnt, 1);

    // write-then-read and same-cycle read
    drv_valid[0] = 1'b1; drv_addr[0] = 7'h05; drv_data[0] = 5'h1A;
    drv_rd = 1'b1; drv_rd_addr = 7'h05;
    step(); chk("wr05_grant", obs_ready, 4'b0001);
    idle_inputs();
    drv_rd = 1'b1; drv_rd_addr = 7'h05;
    step();
    idle_inputs();
    step(); chk("same_cyc_rdv", obs_rdv, 1); chk("same_cyc_rdd", obs_rdd, 0);
    step(); chk("next_cyc_rdv", obs_rdv, 1); chk("next_cyc_rdd", obs_rdd, 5'h1A);

    // cfg_clear with a read in flight
    drv_rd = 1'b1; drv_rd_addr = 7'h05;
    step();
    idle_inputs();
    drv_clr = 1'b1;
    step();
    drv_clr = 1'b0;
    step(); chk("clr_rdv", obs_rdv, 1); chk("clr_rdd", obs_rdd, 5'h1A);
    wait_init("clr");
    drv_rd = 1'b1; drv_rd_addr = 7'h05;
    step();
    idle_inputs();
    step();
    step(); chk("clr_zero_rdv", obs_rdv, 1); chk("clr_zero_rdd", obs_rdd, 0);

    // sustained collision saturates coll_cnt
    drv_valid[0] = 1'b1; drv_addr[0] = 7'h33; drv_data[0] = 5'h0F;
    drv_valid[1] = 1'b1; drv_addr[1] = 7'h33; drv_data[1] = 5'h11;
    repeat (300) step();
    idle_inputs();
    step(); chk("coll_sat", coll_cnt, 255);

    rand_traffic(800, 7);
    rand_traffic(300, 127);

    // reset mid-RUN, then again mid-sweep
    idle_inputs();
    drv_rst = 1'b0; step(); step();
    drv_rst = 1'b1;
    repeat (60) step();
    chk("mid_sweep_busy", init_done, 0);
    drv_rst = 1'b0; step();
    drv_rst = 1'b1;
    wait_init("rerst");
    chk("rerst_coll", coll_cnt, 0);
    rand_traffic(300, 15);

    idle_inputs();
    repeat (4) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lvt_wr_sched.md
LVT_WR_SCHED -- requirements
Module: lvt_wr_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of write requesters (fixed 4 in this revision).
REQ-002 SHALL have parameter AW, default 7, memory address width (128 entries).
REQ-003 SHALL have parameter DW, default 5, write data width.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-low (0 = reset).
REQ-006 SHALL have port cfg_clear  in  1  pulse; in RUN, restarts memory initialisation.
REQ-007 SHALL have port req_valid  in  NREQ  per-requester write request.
REQ-008 SHALL have port req_addr  in  NREQ*AW  packed write addresses, requester i at [i*AW +: AW].
REQ-009 SHALL have port req_data  in  NREQ*DW  packed write data, requester i at [i*DW +: DW].
REQ-010 SHALL have port req_ready  out  NREQ  combinational grant; transfer when valid&ready.
REQ-011 SHALL have port rd_valid_in  in  1  read request.
REQ-012 SHALL have port rd_addr  in  AW  read address.
REQ-013 SHALL have port rd_ready  out  1  read accept.
REQ-014 SHALL have port rd_valid  out  1  read result valid.
REQ-015 SHALL have port rd_data  out  DW  read result.
REQ-016 SHALL have ports wr0_en/wr0_addr/wr0_data and wr1_en/wr1_addr/wr1_data  out  1/AW/DW  registered LVT memory write ports.
REQ-017 SHALL have ports rd0_en/rd0_addr  out  1/AW  registered LVT memory read port; rd0_data  in  DW  read result, valid one cycle after rd0_en.
REQ-018 SHALL have port init_done  out  1  high in RUN.
REQ-019 SHALL have port coll_cnt  out  8  saturating count of address-collision cycles.

Function
REQ-020 SHALL implement FSM states INIT and RUN; INIT -> RUN after address 2**AW-1 is issued; RUN -> INIT on cfg_clear=1.
REQ-021 In INIT SHALL drive req_ready=0, rd_ready=0, wr1_en=0, and issue wr0_en=1, wr0_addr=sweep counter, wr0_data=0 each cycle, counter 0..127, one address per cycle.
REQ-022 Entering INIT SHALL reset the sweep counter to 0; cfg_clear in INIT SHALL be ignored.
REQ-023 In RUN SHALL keep a 2-bit round-robin pointer ptr; SHALL scan requesters ptr, ptr+1, ... (mod 4) and grant the first valid one (winner A) to port 0.
REQ-024 SHALL continue the scan and grant the next valid requester whose address differs from A's to port 1 (winner B); at most two grants per cycle.
REQ-025 A valid requester skipped because its address equals A's SHALL receive req_ready=0 and SHALL increment coll_cnt by 1 per cycle (once per cycle regardless of skip count), saturating at 255.
REQ-026 After a cycle with at least one grant, ptr SHALL become (index of last grant + 1) mod 4; with no grant, ptr SHALL be unchanged.
REQ-027 A write handshake in cycle t SHALL appear on its wrN_* port in cycle t+1; unused ports SHALL have wrN_en=0.
REQ-028 In RUN rd_ready SHALL equal 1; a read handshake at t SHALL drive rd0_en=1, rd0_addr at t+1 and rd_valid=1, rd_data=rd0_data at t+2; one read per cycle, fully pipelined.
REQ-029 A read and a write to the same address handshaken in the same cycle SHALL return the prior value; a write handshaken at t SHALL be visible to reads handshaken at t+1 or later.
REQ-030 Reads in flight when cfg_clear is taken SHALL still complete with rd_valid; writes issued before INIT SHALL be overwritten by the sweep.

Reset
REQ-031 With rst=0 at a clock edge SHALL enter INIT, sweep counter=0, ptr=0, coll_cnt=0, all wrN_en/rd0_en/rd_valid=0, init_done=0; in-flight reads SHALL be discarded.
REQ-032 Reset asserted mid-sweep or mid-RUN SHALL restart the full 128-cycle sweep after release.

Verification
REQ-033 Release reset, no requests -> wr0_en high with addr 0..127 over 128 consecutive cycles, then init_done=1, req_ready responds.
REQ-034 RUN, ptr=0, all four valid with distinct addrs -> grants req 0,1 (port0=0, port1=1); next cycle grants 2,3; then 0,1.
REQ-035 RUN, req0 and req1 both addr 0x10, req2 addr 0x20 -> grant 0 (port0), 2 (port1), req1 held, coll_cnt 0->1.
REQ-036 Write 0x1A to 0x05 at t, read 0x05 at t+1 -> rd_valid at t+3 with rd_data=0x1A; same-cycle read returns 0.
REQ-037 Assert cfg_clear in RUN with a read in flight -> read completes, then 128-cycle zero sweep, reads of any address return 0.
REQ-038 Hold a same-address collision for 300 cycles -> coll_cnt stops at 255.
